// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// fixed enable-to-completed latency the ALU and benches rely on.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    function automatic int div_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// ALU <-> divider handshake: enable pulse with operands in, completed pulse with results out.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             is_signed;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic             completed;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;

    modport master (
        output enable, is_signed, s, t,
        input  completed, q, r, busy
    );

    modport slave (
        input  enable, is_signed, s, t,
        output completed, q, r, busy
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M div/divu/rem/remu with fixed WIDTH+1 latency.
// Divide-by-zero and signed overflow are resolved here so the ALU needs no fix-up.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    seq_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic [WIDTH-1:0] s_raw_reg, s_raw_next;
    logic             sign_s_reg, sign_s_next;
    logic             sign_t_reg, sign_t_next;
    logic             div_zero_reg, div_zero_next;
    logic             completed_reg, completed_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // One restoring step: shift {rem,quo} left, try subtracting the divisor.
    // The remainder is always below the divisor, so a non-negative trial fits in WIDTH bits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH+1:0] trial;
        trial = {1'b0, rem, quo[WIDTH-1]} - {2'b00, d};
        if (trial[WIDTH+1:WIDTH] == 2'b00)
            return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        else
            return {rem[WIDTH-2:0], quo[WIDTH-1], quo[WIDTH-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            divisor_reg   <= '0;
            s_raw_reg     <= '0;
            sign_s_reg    <= 1'b0;
            sign_t_reg    <= 1'b0;
            div_zero_reg  <= 1'b0;
            completed_reg <= 1'b0;
            q_reg         <= '0;
            r_reg         <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            divisor_reg   <= divisor_next;
            s_raw_reg     <= s_raw_next;
            sign_s_reg    <= sign_s_next;
            sign_t_reg    <= sign_t_next;
            div_zero_reg  <= div_zero_next;
            completed_reg <= completed_next;
            q_reg         <= q_next;
            r_reg         <= r_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        divisor_next   = divisor_reg;
        s_raw_next     = s_raw_reg;
        sign_s_next    = sign_s_reg;
        sign_t_next    = sign_t_reg;
        div_zero_next  = div_zero_reg;
        completed_next = 1'b0;
        q_next         = q_reg;
        r_next         = r_reg;

        case (state_reg)
            IDLE: begin
                if (bus.enable) begin
                    sign_s_next   = bus.is_signed & bus.s[WIDTH-1];
                    sign_t_next   = bus.is_signed & bus.t[WIDTH-1];
                    quo_next      = (bus.is_signed & bus.s[WIDTH-1]) ? negate(bus.s) : bus.s;
                    divisor_next  = (bus.is_signed & bus.t[WIDTH-1]) ? negate(bus.t) : bus.t;
                    rem_next      = '0;
                    div_zero_next = (bus.t == '0);
                    s_raw_next    = bus.s;
                    count_next    = '0;
                    state_next    = CALC;
                end
            end
            CALC: begin
                {rem_next, quo_next} = div_step(rem_reg, quo_reg, divisor_reg);
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_ITER)
                    state_next = FIX;
            end
            FIX: begin
                if (div_zero_reg) begin
                    q_next = '1;
                    r_next = s_raw_reg;
                end else begin
                    q_next = (sign_s_reg ^ sign_t_reg) ? negate(quo_reg) : quo_reg;
                    r_next = sign_s_reg ? negate(rem_reg) : rem_reg;
                end
                completed_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.completed = completed_reg;
    assign bus.q         = q_reg;
    assign bus.r         = r_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider. It is the responder side of the ALU's enable/completed multi-cycle handshake and serves RV32M div/divu/rem/remu.
- The ALU pulses `enable` with operands and signedness. The block returns quotient and remainder with a one-cycle `completed` pulse after a fixed latency.
- RISC-V corner cases (divide by zero, signed overflow) are resolved inside the block, so the initiator may rely on it alone.

Parameters:
- WIDTH, 32, operand/result width in bits; counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  clock, all flops on rising edge
- rstn  in  1  reset, asynchronous, active-low
- enable  in  1  start request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands (div/rem), 0 = unsigned (divu/remu)
- s  in  WIDTH  dividend
- t  in  WIDTH  divisor
- completed  out  1  one-cycle pulse; q/r valid in that cycle
- q  out  WIDTH  quotient, held until next completion
- r  out  WIDTH  remainder, held until next completion
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rstn low, asynchronous, any state):
  - state=IDLE, completed=0, q=0, r=0, busy=0.
  - Internal registers are cleared; any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - On a rising edge with enable=1 (edge E0), capture the following and go to CALC, count=0:
    - sign_s = is_signed & s[W-1] and sign_t = is_signed & t[W-1];
    - magnitudes |s| and |t| (negate when the sign bit is set);
    - div_zero = (t==0) and the raw dividend s.
  - enable=0: stay in IDLE.
- CALC, one iteration per edge:
  - Shift {rem,quo} left by 1 and bring in the dividend MSB.
  - trial = rem - |t| (WIDTH+1 bits). If trial is non-negative, rem=trial and quo bit=1; otherwise rem is unchanged and quo bit=0.
  - count increments; the edge completing iteration WIDTH-1 (E_WIDTH) goes to FIX.
- FIX, one edge (E_WIDTH+1):
  - If div_zero: q = all ones, r = raw s (both signedness modes).
  - Otherwise, quotient sign is sign_s ^ sign_t; remainder sign follows sign_s. Negate the magnitudes accordingly.
  - Signed 0x80000000 / 0xFFFFFFFF falls out naturally as q=0x80000000, r=0; no special path is needed.
  - completed<=1 and state<=IDLE.
- completed:
  - High exactly one cycle; cleared on the next edge.
  - Latency is fixed: completed is visible WIDTH+1 edges after E0 (33 for WIDTH=32), independent of operand values.
- Back-to-back: enable high in the cycle completed is high is sampled in IDLE at that edge and starts a new operation. completed still drops at that edge.
- enable while busy is ignored, and operand changes while busy have no effect; operands are latched at E0 only.
- q/r are written only in FIX and are never X after reset.
- No abort input; only rstn cancels an operation.

Decomposition:
- Shared definitions package: state enum typedef (IDLE, CALC, FIX) and a DIV_LATENCY = WIDTH+1 constant so the ALU and benches share it.
- No sub-module. The single add/subtract step and the negate logic are small enough for local functions inside seq_divider.

Test Plan:
1. Unsigned basic: is_signed=0, s=100, t=7, one-cycle enable -> q=14, r=2; completed high exactly at edge E0+33 for one cycle; busy high E0+1..E0+33.
2. Signed sign mix: is_signed=1, s=0xFFFFFFF9 (-7), t=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Then s=7, t=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
3. Divide by zero:
   - is_signed=1, s=0xFFFFFF9C, t=0 -> q=0xFFFFFFFF, r=0xFFFFFF9C.
   - is_signed=0, s=5, t=0 -> q=0xFFFFFFFF, r=5.
   - Same 33-edge latency in both cases.
4. Overflow/width corners:
   - signed s=0x80000000, t=0xFFFFFFFF -> q=0x80000000, r=0.
   - unsigned same operands -> q=0, r=0x80000000.
   - unsigned s=0xFFFFFFFF, t=1 -> q=0xFFFFFFFF, r=0.
5. Handshake:
   - Re-pulse enable with s=9, t=3 during CALC -> ignored; first result 100/7 returned.
   - enable high in the completed cycle with s=9, t=3 -> second completion 33 edges later with q=3, r=0.
6. Reset mid-operation: drop rstn asynchronously (between edges) at iteration 10 -> completed=0, q=0, r=0, busy=0 immediately. After release, 100/7 completes correctly with full latency.
